game_controller: RTL and testbench
==================================

# game_controller

Top-level sequencer for the Starflux game datapath. Runs the title, play and game-over phases, and generates the datapath enables (`startGameEn`, `shipUpdateEn`, `gridUpdateEn`, `current_score_update`, `health_update`, `gameover_signal`) in a fixed per-frame order. Handshakes with the VGA drawer once per frame. Sits between the board I/O (KEY/clock) and the datapath plus drawer.

## Interface
Parameters:
- `FRAME_DIV`, default 833333: clk cycles per frame tick (50 MHz / 60 Hz). Legal range is 2 to 2^20-1. Benches use 4.

Ports:
- `clk`  in  1  50 MHz system clock
- `reset`  in  1  synchronous, active-low reset. Sampled on the rising edge of `clk`.
- `start`  in  1  start button, level, already synchronised. Only its rising edge is used.
- `hit_enemy`  in  1  collision: player bullet struck the enemy (single-cycle or level)
- `hit_user`  in  1  collision: enemy bullet struck the ship
- `ship_health`  in  4  current health from the datapath
- `draw_done`  in  1  drawer has finished the frame
- `startGameEn`  out  1  datapath game init strobe
- `shipUpdateEn`  out  1  ship/enemy movement strobe
- `gridUpdateEn`  out  1  bullet grid shift strobe
- `current_score_update`  out  1  score increment strobe
- `health_update`  out  1  health decrement strobe
- `gameover_signal`  out  1  game-over strobe (latches highscore)
- `draw_req`  out  1  frame draw request
- `state`  out  3  current state encoding, for debug and HEX display

## Operation
- The FSM has eight states: IDLE=0, INIT=1, WAIT=2, SHIP=3, GRID=4, CHECK=5, DRAW=6, OVER=7.
- A start edge is defined as `start`=1 while the previous-cycle `start`=0. The edge register resets to 1, so holding the button through reset does not start a game.
- State transitions:
  - IDLE → INIT on a start edge.
  - INIT → WAIT unconditionally.
  - WAIT → SHIP when `frame_cnt` = FRAME_DIV-1.
  - SHIP → GRID, then GRID → CHECK, then CHECK → DRAW, all unconditionally.
  - DRAW → OVER if `draw_done`=1 and `ship_health`=0.
  - DRAW → WAIT if `draw_done`=1 and `ship_health`≠0.
  - DRAW holds while `draw_done`=0.
  - OVER → INIT on a start edge.
- Outputs are Moore outputs, high only in these states:
  - `startGameEn`: INIT
  - `shipUpdateEn`: SHIP
  - `gridUpdateEn`: GRID
  - `draw_req`: DRAW
  - `gameover_signal`: the first cycle of OVER only, driven from a one-cycle entry flag
  - `current_score_update`: CHECK and `enemy_hit_pend`=1
  - `health_update`: CHECK and `user_hit_pend`=1
- Frame counter `frame_cnt` is 20 bits. It is cleared on entry to WAIT and increments by 1 each WAIT cycle. It never wraps: the WAIT exit happens at FRAME_DIV-1.
- Hit latches `enemy_hit_pend` and `user_hit_pend`:
  - Each is set by its hit input in states WAIT, SHIP, GRID, CHECK and DRAW.
  - Both are cleared at the end of CHECK.
  - If a hit arrives in the same cycle as CHECK, the latch is set again after the clear, so that hit is reported next frame. No hit is lost, and any number of hits within one frame produces one pulse.
  - Both latches are cleared in IDLE, INIT and OVER. Hits arriving in those states are ignored.
- `draw_done` is ignored outside DRAW.
- `ship_health` is sampled only in DRAW on the `draw_done` cycle. This is at least one cycle after the `health_update` pulse, so the decremented value is visible.
- Reset (`reset`=0 at a clock edge), from any state including mid-DRAW:
  - state goes to IDLE
  - all outputs go to 0
  - `frame_cnt` and both latches go to 0
- `draw_req` drops in the cycle after reset even if the drawer is busy. The drawer must tolerate an abandoned request.

## Timing
- All outputs are 0 out of reset, `state`=0.
- From the start edge at cycle n:
  - `startGameEn`=1 at n+1
  - WAIT from n+2 for FRAME_DIV cycles
  - `shipUpdateEn` at n+2+FRAME_DIV
  - `gridUpdateEn` one cycle later
  - CHECK one cycle later
  - `draw_req` rises the next cycle
- `draw_req` stays high up to and including the cycle where `draw_done`=1 is sampled, and is low the following cycle.
- Frame period is FRAME_DIV + 3 + D cycles, where D ≥ 1 is the number of DRAW cycles. A slow drawer stretches the frame; no frame is ever skipped.
- Each strobe is exactly one cycle wide. `shipUpdateEn` and `gridUpdateEn` are never high together.

## Test plan
- Reset hold: `reset`=0 for 3 cycles with `start`=1 → `state`=0 and all outputs 0. Releasing reset with `start` still 1 gives no transition; a 0→1 toggle then gives INIT.
- Frame sequence (FRAME_DIV=4, `draw_done` returns after 2 cycles, `ship_health`=3):
  - start edge at cycle 10 → `startGameEn`@11, `shipUpdateEn`@16, `gridUpdateEn`@17, `draw_req`@19–20
  - next `shipUpdateEn`@25
- Hits: `hit_enemy` pulsed twice in WAIT, `hit_user` pulsed in the CHECK cycle → one `current_score_update` in that CHECK, no `health_update`. One `health_update` in the next frame's CHECK.
- Game over: `ship_health`=0 when `draw_done` is asserted → `state`=7 and `gameover_signal` high exactly one cycle. No further strobes. A start edge then gives `startGameEn` one cycle later.
- Stalled drawer: `draw_done` held 0 for 50 cycles → `draw_req` stays high and no `shipUpdateEn` is issued. `reset`=0 mid-DRAW gives `draw_req`=0 and `state`=0 the next cycle.
- Spurious `draw_done`=1 during WAIT → ignored: `frame_cnt` and WAIT→SHIP timing unchanged.

Source files
------------

// File: rtl/game_controller.sv
// ---------------------------------------------------------------------------
// game_controller
//
// Top-level sequencer for the Starflux game datapath. Walks the title, play
// and game-over phases and issues the datapath enables in a fixed per-frame
// order: wait for the frame tick, move ship/enemy, shift the bullet grid,
// apply score/health, then hand the frame to the VGA drawer and wait for it.
//
// Parameters:
//   FRAME_DIV             clk cycles per frame tick (2 .. 2^20-1)
//
// Ports:
//   clk                   system clock
//   reset                 synchronous, active-low reset
//   start                 start button level (already synchronised)
//   hit_enemy             player bullet struck the enemy
//   hit_user              enemy bullet struck the ship
//   ship_health[3:0]      current ship health from the datapath
//   draw_done             drawer has finished the frame
//   startGameEn           datapath game init strobe
//   shipUpdateEn          ship/enemy movement strobe
//   gridUpdateEn          bullet grid shift strobe
//   current_score_update  score increment strobe
//   health_update         health decrement strobe
//   gameover_signal       game-over strobe (latches highscore)
//   draw_req              frame draw request to the drawer
//   state[2:0]            current state encoding (debug / HEX display)
// ---------------------------------------------------------------------------
module game_controller #(
  parameter int FRAME_DIV = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hit_enemy,
  input  logic       hit_user,
  input  logic [3:0] ship_health,
  input  logic       draw_done,
  output logic       startGameEn,
  output logic       shipUpdateEn,
  output logic       gridUpdateEn,
  output logic       current_score_update,
  output logic       health_update,
  output logic       gameover_signal,
  output logic       draw_req,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIP  = 3'd3,
    S_GRID  = 3'd4,
    S_CHECK = 3'd5,
    S_DRAW  = 3'd6,
    S_OVER  = 3'd7
  } state_t;

  localparam logic [19:0] FRAME_LAST = 20'(FRAME_DIV - 1);

  state_t      state_q;
  state_t      state_d;
  logic [19:0] frame_cnt;
  logic        start_prev;
  logic        start_edge;
  logic        enemy_hit_pend;
  logic        user_hit_pend;
  logic        enemy_pend_d;
  logic        user_pend_d;
  logic        in_frame;

  // start_prev comes out of reset high, so a button held through reset
  // does not look like a fresh press.
  assign start_edge = start & ~start_prev;

  assign in_frame = (state_q == S_WAIT) || (state_q == S_SHIP) ||
                    (state_q == S_GRID) || (state_q == S_CHECK) ||
                    (state_q == S_DRAW);

  assign state = state_q;

  // Next-state logic. draw_done and ship_health only matter in DRAW, so a
  // stray draw_done elsewhere cannot disturb frame timing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_edge) state_d = S_INIT;
      S_INIT:  state_d = S_WAIT;
      S_WAIT:  if (frame_cnt == FRAME_LAST) state_d = S_SHIP;
      S_SHIP:  state_d = S_GRID;
      S_GRID:  state_d = S_CHECK;
      S_CHECK: state_d = S_DRAW;
      S_DRAW: begin
        if (draw_done) begin
          state_d = (ship_health == 4'd0) ? S_OVER : S_WAIT;
        end
      end
      S_OVER:  if (start_edge) state_d = S_INIT;
      default: state_d = S_IDLE;
    endcase
  end

  // Hit latches. CHECK consumes the pending hits, but a hit landing in the
  // CHECK cycle itself reloads the latch so it is reported next frame.
  // Outside a running frame the latches are held clear.
  always_comb begin
    enemy_pend_d = 1'b0;
    user_pend_d  = 1'b0;
    if (in_frame) begin
      if (state_q == S_CHECK) begin
        enemy_pend_d = hit_enemy;
        user_pend_d  = hit_user;
      end else begin
        enemy_pend_d = enemy_hit_pend | hit_enemy;
        user_pend_d  = user_hit_pend | hit_user;
      end
    end
  end

  // State, counters, latches and registered Moore outputs. Outputs are
  // decoded from the next state so each strobe lines up with its state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q              <= S_IDLE;
      frame_cnt            <= '0;
      start_prev           <= 1'b1;
      enemy_hit_pend       <= 1'b0;
      user_hit_pend        <= 1'b0;
      startGameEn          <= 1'b0;
      shipUpdateEn         <= 1'b0;
      gridUpdateEn         <= 1'b0;
      current_score_update <= 1'b0;
      health_update        <= 1'b0;
      gameover_signal      <= 1'b0;
      draw_req             <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_prev     <= start;
      enemy_hit_pend <= enemy_pend_d;
      user_hit_pend  <= user_pend_d;

      // Cleared on WAIT entry; the exit happens at FRAME_LAST so it never wraps.
      if (state_d == S_WAIT && state_q != S_WAIT) begin
        frame_cnt <= '0;
      end else if (state_d == S_WAIT && state_q == S_WAIT) begin
        frame_cnt <= frame_cnt + 20'd1;
      end

      startGameEn          <= (state_d == S_INIT);
      shipUpdateEn         <= (state_d == S_SHIP);
      gridUpdateEn         <= (state_d == S_GRID);
      current_score_update <= (state_d == S_CHECK) && enemy_pend_d;
      health_update        <= (state_d == S_CHECK) && user_pend_d;
      gameover_signal      <= (state_d == S_OVER) && (state_q != S_OVER);
      draw_req             <= (state_d == S_DRAW);
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// ---------------------------------------------------------------------------
// tb_game_controller
//
// Directed bench for game_controller with FRAME_DIV=4. The stimulus process
// drives one period at a time and pushes the hand-derived output vector and
// state expected in that period; a separate monitor pops and compares them
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_game_controller;

  localparam int FRAME_DIV = 4;

  // Strobe vector order:
  // {startGameEn, shipUpdateEn, gridUpdateEn, score, health, gameover, draw_req}
  localparam logic [6:0] V_NONE  = 7'b0000000;
  localparam logic [6:0] V_START = 7'b1000000;
  localparam logic [6:0] V_SHIP  = 7'b0100000;
  localparam logic [6:0] V_GRID  = 7'b0010000;
  localparam logic [6:0] V_OVER  = 7'b0000010;
  localparam logic [6:0] V_DRAW  = 7'b0000001;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_SHIP  = 3'd3;
  localparam logic [2:0] ST_GRID  = 3'd4;
  localparam logic [2:0] ST_CHECK = 3'd5;
  localparam logic [2:0] ST_DRAW  = 3'd6;
  localparam logic [2:0] ST_OVER  = 3'd7;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       hit_enemy;
  logic       hit_user;
  logic [3:0] ship_health;
  logic       draw_done;
  logic       startGameEn;
  logic       shipUpdateEn;
  logic       gridUpdateEn;
  logic       current_score_update;
  logic       health_update;
  logic       gameover_signal;
  logic       draw_req;
  logic [2:0] state;

  typedef struct {
    int         cyc;
    logic [6:0] vec;
    logic [2:0] st;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc          = 0;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  game_controller #(.FRAME_DIV(FRAME_DIV)) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .hit_enemy            (hit_enemy),
    .hit_user             (hit_user),
    .ship_health          (ship_health),
    .draw_done            (draw_done),
    .startGameEn          (startGameEn),
    .shipUpdateEn         (shipUpdateEn),
    .gridUpdateEn         (gridUpdateEn),
    .current_score_update (current_score_update),
    .health_update        (health_update),
    .gameover_signal      (gameover_signal),
    .draw_req             (draw_req),
    .state                (state)
  );

  always #5 clk = ~clk;

  // Period number: period k is the interval following rising edge k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input exp_t e);
    logic [6:0] act;
    act = {startGameEn, shipUpdateEn, gridUpdateEn, current_score_update,
           health_update, gameover_signal, draw_req};
    n_compared++;
    if (act !== e.vec) begin
      n_mismatched++;
      $display("[TB] FAIL %s strobes @cycle %0d: got %b, required %b", e.tag, e.cyc, act, e.vec);
    end
    n_compared++;
    if (state !== e.st) begin
      n_mismatched++;
      $display("[TB] FAIL %s state @cycle %0d: got %0d, required %0d", e.tag, e.cyc, state, e.st);
    end
  endtask

  // Monitor: compares every expectation registered for the current period.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        if (e.cyc < cyc) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL %s missed @cycle %0d: got no sample, required one", e.tag, e.cyc);
        end else begin
          check_output(e);
        end
      end
    end
  end

  // Drive inputs for the current period, register what the DUT must show
  // in this same period, then advance to the next period.
  task automatic apply_stimulus(input logic s, input logic he, input logic hu,
                                input logic dd, input logic [3:0] hp,
                                input logic [6:0] vec, input logic [2:0] st,
                                input string tag);
    exp_t e;
    start       = s;
    hit_enemy   = he;
    hit_user    = hu;
    draw_done   = dd;
    ship_health = hp;
    e.cyc = cyc;
    e.vec = vec;
    e.st  = st;
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // One frame starting at its first WAIT period. Frame positions:
  // 0..FRAME_DIV-1 WAIT, then SHIP, GRID, CHECK, then d DRAW periods.
  task automatic run_frame(input int d, input logic [3:0] hp,
                           input logic [31:0] en_mask, input logic [31:0] us_mask,
                           input logic [31:0] dd_mask,
                           input logic exp_sc, input logic exp_he,
                           input logic finish, input string tag);
    int last;
    last = FRAME_DIV + 3 + d - 1;
    for (int pos = 0; pos <= last; pos++) begin
      logic [6:0] v;
      logic [2:0] st;
      logic       en;
      logic       us;
      logic       dd;
      if (pos < FRAME_DIV) begin
        v = V_NONE;  st = ST_WAIT;
      end else if (pos == FRAME_DIV) begin
        v = V_SHIP;  st = ST_SHIP;
      end else if (pos == FRAME_DIV + 1) begin
        v = V_GRID;  st = ST_GRID;
      end else if (pos == FRAME_DIV + 2) begin
        v = {3'b000, exp_sc, exp_he, 2'b00};  st = ST_CHECK;
      end else begin
        v = V_DRAW;  st = ST_DRAW;
      end
      en = (pos < 32) ? en_mask[pos] : 1'b0;
      us = (pos < 32) ? us_mask[pos] : 1'b0;
      dd = ((pos == last) && finish) | ((pos < 32) ? dd_mask[pos] : 1'b0);
      apply_stimulus(1'b0, en, us, dd, hp, v, st, tag);
    end
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b1;
    hit_enemy   = 1'b0;
    hit_user    = 1'b0;
    draw_done   = 1'b0;
    ship_health = 4'd3;
    @(posedge clk);
    #1;

    // Reset held with the button pressed.
    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, V_NONE, ST_IDLE, "reset_hold");
    reset = 1'b1;
    // Button still held after release, plus hits in IDLE: all ignored.
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, V_NONE, ST_IDLE, "reset_release");
    repeat (2) apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, V_NONE, ST_IDLE, "held_start");
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd3, V_NONE, ST_IDLE, "start_low");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, V_NONE, ST_IDLE, "start_edge");
    // Hits during INIT are dropped.
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd3, V_START, ST_INIT, "init");

    // Spurious draw_done in WAIT (including the exit period) changes nothing.
    run_frame(2, 4'd3, 32'h0, 32'h0, 32'h0000_000A, 1'b0, 1'b0, 1'b1, "frame1_spurious_done");
    // Two enemy hits in WAIT, user hit in CHECK: one score pulse only.
    run_frame(2, 4'd3, 32'h0000_0006, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 1'b1, "frame2_hits");
    // Carried user hit reported; enemy hit during DRAW goes pending.
    run_frame(3, 4'd3, 32'h0000_0080, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, "frame3_carry");
    // Health reads 0 when the drawer finishes: game over. User hit on the
    // final DRAW period must not survive into the next game.
    run_frame(2, 4'd0, 32'h0, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 1'b1, "frame4_last");

    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, V_OVER, ST_OVER, "gameover_pulse");
    repeat (3) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, V_NONE, ST_OVER, "over_hold");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, V_NONE, ST_OVER, "restart_edge");
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd3, V_START, ST_INIT, "restart_init");

    run_frame(2, 4'd3, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "frame5_after_over");

    // Stalled drawer for 50 periods, then reset mid-DRAW.
    run_frame(50, 4'd3, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "stall");
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd3, V_DRAW, ST_DRAW, "reset_mid_draw");
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd3, V_NONE, ST_IDLE, "after_reset");
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd3, V_NONE, ST_IDLE, "idle_quiet");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
